// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, character width and the
// receiver state encoding. Also used by the TX side.
package uart_pkg;
  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 8;
  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } uart_rx_state_t;
endpackage

// File: rtl/uart_rx_oversample_if.sv
// Serial line plus received-character outputs of the UART receiver.
// slave: the receiver. master: whoever drives rxd and consumes characters.
interface uart_rx_oversample_if;
  import uart_pkg::*;
  logic                   rxd;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_done;
  logic                   frame_err;
  logic                   parity_err;
  logic                   busy;

  modport master (output rxd, input rx_data, rx_done, frame_err, parity_err, busy);
  modport slave  (input rxd, output rx_data, rx_done, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// CLK_DIV divider producing a one-cycle tick at each wrap of a 0..CLK_DIV-1
// counter. restart realigns the phase so the next tick is CLK_DIV cycles away.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: wrap at LAST, or jump to phase 0 on restart
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || cnt_q == LAST) cnt_d = '0;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN for 8E1 framing with an active parity_err output.
// rx_data/rx_done rise together one clk after the stop-bit sample; the
// falling edge of rx_done marks rx_data valid for the downstream stage.
module uart_rx_oversample import uart_pkg::*; #(
  parameter int CLK_DIV  = 27,
  parameter int DONE_LEN = 4
) (
  input logic                 clk,
  input logic                 reset,
  uart_rx_oversample_if.slave rx_if
);
  localparam int DW = $clog2(DONE_LEN);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

  logic s1_q, s2_q, prev_q;
  logic fall, restart, tick, mid_hit;

  uart_rx_state_t         state_q;
  logic [3:0]             samp_q;
  logic [2:0]             bit_q;
  logic [UART_DATA_W-1:0] shift_q, data_q;
  logic [DW-1:0]          done_cnt_q;
  logic                   done_q, ferr_q, busy_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, perr_q;
`endif

  // 2-FF synchronizer plus delayed copy for edge detection; idle-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rx_if.rxd;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // a start is only ever accepted from IDLE; a held-low line never re-triggers
  assign fall    = prev_q & ~s2_q;
  assign restart = (state_q == IDLE) && fall;
  assign mid_hit = tick && (samp_q == 4'(OVERSAMPLE - 1));

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // receive FSM with registered outputs; samp_q wraps 15->0 once per bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_cnt_q <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: if (fall) begin
          state_q <= START;
          samp_q  <= '0;
          busy_q  <= 1'b1;
        end
        START: if (tick) begin
          if (samp_q == 4'(MID_SAMPLE - 1)) begin
            samp_q <= '0;
            bit_q  <= '0;
            if (!s2_q) state_q <= DATA;
            else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else samp_q <= samp_q + 4'd1;
        end
        DATA: begin
          if (tick) samp_q <= samp_q + 4'd1;
          if (mid_hit) begin
            shift_q <= {s2_q, shift_q[UART_DATA_W-1:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'(UART_DATA_W - 1)) state_q <= AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) samp_q <= samp_q + 4'd1;
          if (mid_hit) begin
            par_bad_q <= (s2_q != ^shift_q);
            state_q   <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) samp_q <= samp_q + 4'd1;
          if (mid_hit) begin
            if (s2_q) begin
              data_q     <= shift_q;
              done_q     <= 1'b1;
              done_cnt_q <= '0;
              state_q    <= DONE;
`ifdef UART_RX_PARITY_EN
              perr_q     <= par_bad_q;
`endif
            end else begin
              ferr_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          if (done_cnt_q == DW'(DONE_LEN - 1)) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else done_cnt_q <= done_cnt_q + DW'(1);
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_done   = done_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = perr_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample with CLK_DIV=2, DONE_LEN=4 (32 clk/bit).
// Each frame sent registers an expected event (detection, output cycle, return
// to idle) computed from sync latency and the 8+16k sample points; a negedge
// process checks every output against those events on every cycle.
module tb_uart_rx_oversample;
  import uart_pkg::*;
  localparam int CLK_DIV  = 2;
  localparam int DONE_LEN = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int BIT_CYC  = OVERSAMPLE * CLK_DIV;
  localparam int SYNC_LAT = 3;
  localparam int K_GOOD = 0, K_FERR = 1, K_PERR = 2, K_NONE = 3;

  typedef struct {
    int         det;
    int         rise;
    int         idle;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_rx_oversample_if bus();

  uart_rx_oversample #(.CLK_DIV(CLK_DIV), .DONE_LEN(DONE_LEN)) dut (
    .clk  (clk),
    .reset(reset),
    .rx_if(bus)
  );

  always #5 clk = ~clk;

  ev_t        evq[$];
  logic [7:0] got_q[$];
  int cyc = 0;
  logic rst_e = 1'b0;
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_data = 8'h00;
  int done_run = 0, last_rise = -1, done_pulses = 0, ferr_pulses = 0, perr_pulses = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= reset;
  end

  // per-cycle compare against the event model
  always @(negedge clk) begin
    logic e_done, e_ferr, e_perr, e_busy;
    e_done = 1'b0; e_ferr = 1'b0; e_perr = 1'b0; e_busy = 1'b0;
    if (cyc >= 1) begin
      if (rst_e) exp_data = 8'h00;
      else foreach (evq[i]) begin
        if (evq[i].det <= cyc && cyc < evq[i].idle) e_busy = 1'b1;
        if ((evq[i].kind == K_GOOD || evq[i].kind == K_PERR) &&
            evq[i].rise <= cyc && cyc < evq[i].rise + DONE_LEN) begin
          e_done = 1'b1;
          if (cyc == evq[i].rise) exp_data = evq[i].data;
        end
        if (evq[i].kind == K_FERR && cyc == evq[i].rise) e_ferr = 1'b1;
        if (evq[i].kind == K_PERR && cyc == evq[i].rise) e_perr = 1'b1;
      end
      check("rx_data",    32'(bus.rx_data),    32'(exp_data));
      check("rx_done",    32'(bus.rx_done),    32'(e_done));
      check("frame_err",  32'(bus.frame_err),  32'(e_ferr));
      check("parity_err", 32'(bus.parity_err), 32'(e_perr));
      check("busy",       32'(bus.busy),       32'(e_busy));
      if (bus.rx_done === 1'b1) begin
        if (done_run == 0) begin
          last_rise = cyc;
          done_pulses++;
          got_q.push_back(bus.rx_data);
        end
        done_run++;
      end else begin
        if (done_run != 0) check("done_len", 32'(done_run), 32'd4);
        done_run = 0;
      end
      if (bus.frame_err === 1'b1) ferr_pulses++;
      if (bus.parity_err === 1'b1) perr_pulses++;
      while (evq.size() > 0 && evq[0].idle + 2 < cyc && evq[0].rise + DONE_LEN + 2 < cyc)
        void'(evq.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    step(n);
  endtask

  task automatic drive_bit(input logic b);
    bus.rxd = b;
    step(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    ev_t e;
    e.det  = cyc + SYNC_LAT;
    e.rise = cyc + SYNC_LAT + (MID_SAMPLE + OVERSAMPLE * (9 + NPAR)) * CLK_DIV;
    e.data = d;
    if (!stop)                           e.kind = K_FERR;
    else if (NPAR == 1 && pbit != ^d)    e.kind = K_PERR;
    else                                 e.kind = K_GOOD;
    e.idle = stop ? e.rise + DONE_LEN : e.rise;
    evq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (NPAR == 1) drive_bit(pbit);
    drive_bit(stop);
  endtask

  initial begin
    int c0, p0;
    ev_t e;
    bus.rxd = 1'b1;
    reset   = 1'b1;
    step(4);
    check("rst_data", 32'(bus.rx_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    idle(20);

    // 0xA5: output rises 3 + (8+16*9)*2 = 307 cycles after the start bit (339 with parity)
    c0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("a5_rise_offset", 32'(last_rise - c0), 32'd339);
`else
    check("a5_rise_offset", 32'(last_rise - c0), 32'd307);
`endif
    check("a5_data", 32'(bus.rx_data), 32'hA5);
    check("a5_pulses", 32'(done_pulses), 32'd1);
    check("a5_ferr", 32'(ferr_pulses), 32'd0);
    idle(20);

    // 10-cycle low glitch: aborts at tick 8 (cycle +19)
    p0 = done_pulses;
    e.det = cyc + SYNC_LAT; e.idle = cyc + SYNC_LAT + MID_SAMPLE * CLK_DIV;
    e.rise = -100; e.kind = K_NONE; e.data = 8'h00;
    evq.push_back(e);
    bus.rxd = 1'b0;
    step(10);
    idle(40);
    check("glitch_done", 32'(done_pulses), 32'(p0));
    check("glitch_ferr", 32'(ferr_pulses), 32'd0);
    check("glitch_busy", 32'(bus.busy), 32'h0);

    // 0x3C with low stop bit: framing error, rx_data keeps 0xA5
    p0 = done_pulses;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    check("ferr_pulses", 32'(ferr_pulses), 32'd1);
    check("ferr_data", 32'(bus.rx_data), 32'hA5);
    check("ferr_done", 32'(done_pulses), 32'(p0));

    // back-to-back 0x00, 0xFF
    p0 = done_pulses;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(40);
    check("b2b_pulses", 32'(done_pulses), 32'(p0 + 2));
    if (got_q.size() >= 2) begin
      check("b2b_first", 32'(got_q[got_q.size()-2]), 32'h00);
      check("b2b_second", 32'(got_q[got_q.size()-1]), 32'hFF);
    end else check("b2b_count", 32'(got_q.size()), 32'd2);

    // reset during bit 4 of 0x81, then a clean 0x55
    p0 = done_pulses;
    e.det = cyc + SYNC_LAT; e.idle = cyc + 5 * BIT_CYC + BIT_CYC / 2 + 1;
    e.rise = -100; e.kind = K_NONE; e.data = 8'h00;
    evq.push_back(e);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    bus.rxd = 1'b0;
    step(BIT_CYC / 2);
    reset   = 1'b1;
    bus.rxd = 1'b1;
    step(3);
    check("rstmid_data", 32'(bus.rx_data), 32'h00);
    check("rstmid_done", 32'(bus.rx_done), 32'h0);
    check("rstmid_busy", 32'(bus.busy), 32'h0);
    check("rstmid_ferr", 32'(bus.frame_err), 32'h0);
    step(2);
    reset = 1'b0;
    idle(20);
    check("rstmid_nopulse", 32'(done_pulses), 32'(p0));
    send_frame(8'h55, 1'b1, 1'b0);
    idle(40);
    check("r55_data", 32'(bus.rx_data), 32'h55);
    check("r55_pulses", 32'(done_pulses), 32'(p0 + 1));
    check("r55_ferr", 32'(ferr_pulses), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    p0 = done_pulses;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_ok_perr", 32'(perr_pulses), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("par_bad_perr", 32'(perr_pulses), 32'd1);
    check("par_bad_data", 32'(bus.rx_data), 32'h07);
    check("par_pulses", 32'(done_pulses), 32'(p0 + 2));
`else
    check("noparity_perr", 32'(perr_pulses), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
